// File: rtl/cache_pkg.sv
// Shared geometry defaults, derived field widths and refill FSM state type
// for the L1 cache data array.
package cache_pkg;

  localparam int unsigned SETS_DEF       = 64;
  localparam int unsigned LINE_BYTES_DEF = 64;
  localparam int unsigned WAYS_DEF       = 2;
  localparam int unsigned RD_BYTES_DEF   = 4;
  localparam int unsigned FILL_BYTES_DEF = 8;

  // Field width that stays >= 1 so single-way / single-beat builds still elaborate
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned IDX_W = clog2_min1(SETS_DEF);
  localparam int unsigned OFF_W = clog2_min1(LINE_BYTES_DEF);
  localparam int unsigned WAY_W = clog2_min1(WAYS_DEF);
  localparam int unsigned BEATS = LINE_BYTES_DEF / FILL_BYTES_DEF;
  localparam int unsigned CNT_W = clog2_min1(BEATS);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    DONE
  } fill_state_e;

endpackage

// File: rtl/cache_way_bank.sv
// One way of the data array: SETS lines of LINE_BYTES bytes, per-byte write
// enables, combinational whole-line read. Contents are deliberately not reset.
module cache_way_bank
  import cache_pkg::*;
#(
  parameter int unsigned SETS       = SETS_DEF,
  parameter int unsigned LINE_BYTES = LINE_BYTES_DEF
) (
  input  logic                           clk,
  input  logic [clog2_min1(SETS)-1:0]    wr_index,
  input  logic [LINE_BYTES-1:0]          byte_we,
  input  logic [LINE_BYTES*8-1:0]        byte_wdata,
  input  logic [clog2_min1(SETS)-1:0]    rd_index,
  output logic [LINE_BYTES*8-1:0]        rd_line
);

  logic [LINE_BYTES*8-1:0] mem [SETS];

  always_ff @(posedge clk) begin
    for (int unsigned b = 0; b < LINE_BYTES; b++) begin
      if (byte_we[b]) mem[wr_index][b*8 +: 8] <= byte_wdata[b*8 +: 8];
    end
  end

  assign rd_line = mem[rd_index];

endmodule

// File: rtl/cache_data_array.sv
// L1 cache data store: registered byte-offset read port with store forwarding,
// byte-strobed store port, and a valid/ready line-refill engine.
module cache_data_array
  import cache_pkg::*;
#(
  parameter int unsigned SETS       = SETS_DEF,
  parameter int unsigned LINE_BYTES = LINE_BYTES_DEF,
  parameter int unsigned WAYS       = WAYS_DEF,
  parameter int unsigned RD_BYTES   = RD_BYTES_DEF,
  parameter int unsigned FILL_BYTES = FILL_BYTES_DEF
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                rd_en,
  input  logic [clog2_min1(WAYS)-1:0]         rd_way,
  input  logic [clog2_min1(SETS)-1:0]         rd_index,
  input  logic [clog2_min1(LINE_BYTES)-1:0]   rd_offset,
  output logic                                rd_stall,
  output logic                                rd_valid,
  output logic [RD_BYTES*8-1:0]               rd_data,
  input  logic                                wr_en,
  input  logic [clog2_min1(WAYS)-1:0]         wr_way,
  input  logic [clog2_min1(SETS)-1:0]         wr_index,
  input  logic [clog2_min1(LINE_BYTES)-1:0]   wr_offset,
  input  logic [RD_BYTES-1:0]                 wr_strb,
  input  logic [RD_BYTES*8-1:0]               wr_data,
  output logic                                wr_ready,
  input  logic                                fill_start,
  input  logic [clog2_min1(WAYS)-1:0]         fill_way,
  input  logic [clog2_min1(SETS)-1:0]         fill_index,
  input  logic                                fill_valid,
  input  logic [FILL_BYTES*8-1:0]             fill_data,
  output logic                                fill_ready,
  output logic                                fill_busy,
  output logic                                fill_done
);

  localparam int unsigned IDXW   = clog2_min1(SETS);
  localparam int unsigned OFFW   = clog2_min1(LINE_BYTES);
  localparam int unsigned WAYW   = clog2_min1(WAYS);
  localparam int unsigned NBEATS = LINE_BYTES / FILL_BYTES;
  localparam int unsigned CNTW   = clog2_min1(NBEATS);
  localparam int unsigned LINE_W = LINE_BYTES * 8;

  function automatic logic [OFFW-1:0] wrap_add(input logic [OFFW-1:0] base, input int unsigned i);
    return base + OFFW'(i);
  endfunction

  fill_state_e     state_q;
  logic [CNTW-1:0] cnt_q;
  logic [WAYW-1:0] fill_way_q;
  logic [IDXW-1:0] fill_index_q;
  logic            fill_ready_q;
  logic            fill_busy_q;
  logic            fill_done_q;

  logic rd_acc;
  logic wr_acc;
  logic beat_acc;

  logic [LINE_BYTES-1:0] st_we;
  logic [LINE_W-1:0]     st_wdata;
  logic [LINE_BYTES-1:0] fl_we;
  logic [LINE_W-1:0]     fl_wdata;

  logic [LINE_BYTES-1:0] bank_we [WAYS];
  logic [LINE_W-1:0]     bank_wdata;
  logic [IDXW-1:0]       bank_windex;
  logic [LINE_W-1:0]     way_line [WAYS];

  logic [LINE_W-1:0]       fwd_line;
  logic [RD_BYTES*8-1:0]   rd_next;

  assign rd_stall   = fill_busy_q & rd_en & (rd_way == fill_way_q) & (rd_index == fill_index_q);
  assign rd_acc     = rd_en & ~rd_stall;
  assign wr_ready   = ~fill_busy_q;
  assign wr_acc     = wr_en & ~fill_busy_q;
  assign beat_acc   = fill_valid & fill_ready_q;
  assign fill_ready = fill_ready_q;
  assign fill_busy  = fill_busy_q;
  assign fill_done  = fill_done_q;

  // Scatter the store word into line byte lanes, wrapping inside the line
  always_comb begin
    st_we    = '0;
    st_wdata = '0;
    for (int unsigned i = 0; i < RD_BYTES; i++) begin
      st_we[wrap_add(wr_offset, i)]                  = wr_strb[i];
      st_wdata[{wrap_add(wr_offset, i), 3'b000} +: 8] = wr_data[i*8 +: 8];
    end
  end

  always_comb begin
    fl_we    = '0;
    fl_wdata = '0;
    for (int unsigned b = 0; b < LINE_BYTES; b++) begin
      fl_we[b]           = (CNTW'(b / FILL_BYTES) == cnt_q);
      fl_wdata[b*8 +: 8] = fill_data[(b % FILL_BYTES)*8 +: 8];
    end
  end

  // Store and refill writes never coincide: beats need FILL, stores need ~fill_busy
  always_comb begin
    bank_wdata  = beat_acc ? fl_wdata : st_wdata;
    bank_windex = beat_acc ? fill_index_q : wr_index;
    for (int unsigned w = 0; w < WAYS; w++) begin
      bank_we[w] = '0;
      if (wr_acc && wr_way == WAYW'(w))           bank_we[w] = st_we;
      else if (beat_acc && fill_way_q == WAYW'(w)) bank_we[w] = fl_we;
    end
  end

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    cache_way_bank #(
      .SETS       (SETS),
      .LINE_BYTES (LINE_BYTES)
    ) u_bank (
      .clk        (clk),
      .wr_index   (bank_windex),
      .byte_we    (bank_we[w]),
      .byte_wdata (bank_wdata),
      .rd_index   (rd_index),
      .rd_line    (way_line[w])
    );
  end

  // Write-first: a same-cycle store to the read line overrides its strobed bytes
  always_comb begin
    fwd_line = way_line[rd_way];
    if (wr_acc && wr_way == rd_way && wr_index == rd_index) begin
      for (int unsigned b = 0; b < LINE_BYTES; b++) begin
        if (st_we[b]) fwd_line[b*8 +: 8] = st_wdata[b*8 +: 8];
      end
    end
    rd_next = '0;
    for (int unsigned i = 0; i < RD_BYTES; i++) begin
      rd_next[i*8 +: 8] = fwd_line[{wrap_add(rd_offset, i), 3'b000} +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_acc;
      if (rd_acc) rd_data <= rd_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      fill_way_q   <= '0;
      fill_index_q <= '0;
      fill_ready_q <= 1'b0;
      fill_busy_q  <= 1'b0;
      fill_done_q  <= 1'b0;
    end else begin
      fill_done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (fill_start) begin
            state_q      <= FILL;
            fill_way_q   <= fill_way;
            fill_index_q <= fill_index;
            cnt_q        <= '0;
            fill_ready_q <= 1'b1;
            fill_busy_q  <= 1'b1;
          end
        end
        FILL: begin
          if (beat_acc) begin
            if (cnt_q == CNTW'(NBEATS - 1)) begin
              state_q      <= DONE;
              cnt_q        <= '0;
              fill_ready_q <= 1'b0;
              fill_busy_q  <= 1'b0;
              fill_done_q  <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_data_array.sv
// Bench for cache_data_array: table of store/read vectors, read scoreboard,
// and hand-written refill, forwarding and reset-abort sequences.
module tb_cache_data_array;
  import cache_pkg::*;

  localparam int unsigned LAST_BEAT = (1 << CNT_W) - 1;

  logic                        clk = 1'b0;
  logic                        rst;
  logic                        rd_en;
  logic [WAY_W-1:0]            rd_way;
  logic [IDX_W-1:0]            rd_index;
  logic [OFF_W-1:0]            rd_offset;
  logic                        rd_stall;
  logic                        rd_valid;
  logic [31:0]                 rd_data;
  logic                        wr_en;
  logic [WAY_W-1:0]            wr_way;
  logic [IDX_W-1:0]            wr_index;
  logic [OFF_W-1:0]            wr_offset;
  logic [3:0]                  wr_strb;
  logic [31:0]                 wr_data;
  logic                        wr_ready;
  logic                        fill_start;
  logic [WAY_W-1:0]            fill_way;
  logic [IDX_W-1:0]            fill_index;
  logic                        fill_valid;
  logic [FILL_BYTES_DEF*8-1:0] fill_data;
  logic                        fill_ready;
  logic                        fill_busy;
  logic                        fill_done;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mon_exp;

  cache_data_array #(
    .SETS       (SETS_DEF),
    .LINE_BYTES (LINE_BYTES_DEF),
    .WAYS       (WAYS_DEF),
    .RD_BYTES   (RD_BYTES_DEF),
    .FILL_BYTES (FILL_BYTES_DEF)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rd_en      (rd_en),
    .rd_way     (rd_way),
    .rd_index   (rd_index),
    .rd_offset  (rd_offset),
    .rd_stall   (rd_stall),
    .rd_valid   (rd_valid),
    .rd_data    (rd_data),
    .wr_en      (wr_en),
    .wr_way     (wr_way),
    .wr_index   (wr_index),
    .wr_offset  (wr_offset),
    .wr_strb    (wr_strb),
    .wr_data    (wr_data),
    .wr_ready   (wr_ready),
    .fill_start (fill_start),
    .fill_way   (fill_way),
    .fill_index (fill_index),
    .fill_valid (fill_valid),
    .fill_data  (fill_data),
    .fill_ready (fill_ready),
    .fill_busy  (fill_busy),
    .fill_done  (fill_done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rd_valid) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL rd_unexpected: rd_valid=1 data=%h, required no read response", rd_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if (rd_data !== mon_exp) begin
          bad++;
          $display("FAIL rd_data: got %h want %h", rd_data, mon_exp);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] beat(input logic [7:0] base, input int k);
    logic [63:0] d;
    for (int j = 0; j < 8; j++) d[j*8 +: 8] = base + 8'(k*8 + j);
    return d;
  endfunction

  task automatic store(input logic [WAY_W-1:0] w, input logic [IDX_W-1:0] s,
                       input logic [OFF_W-1:0] o, input logic [3:0] sb, input logic [31:0] d);
    wr_en = 1'b1; wr_way = w; wr_index = s; wr_offset = o; wr_strb = sb; wr_data = d;
    chk("wr_ready_idle", wr_ready, 1);
    tick();
    wr_en = 1'b0;
  endtask

  task automatic read_chk(input logic [WAY_W-1:0] w, input logic [IDX_W-1:0] s,
                          input logic [OFF_W-1:0] o, input logic [31:0] e);
    rd_en = 1'b1; rd_way = w; rd_index = s; rd_offset = o;
    exp_q.push_back(e);
    tick();
    rd_en = 1'b0;
    chk("rd_valid", rd_valid, 1);
    @(negedge clk);
    #1;
    chk("rd_drained", exp_q.size(), 0);
  endtask

  task automatic do_fill(input logic [WAY_W-1:0] w, input logic [IDX_W-1:0] s, input logic [7:0] base);
    fill_start = 1'b1; fill_way = w; fill_index = s;
    tick();
    fill_start = 1'b0;
    chk("fill_busy_start", fill_busy, 1);
    chk("fill_ready_start", fill_ready, 1);
    for (int k = 0; k < BEATS; k++) begin
      fill_valid = 1'b1;
      fill_data  = beat(base, k);
      tick();
      chk("fill_done_beat", fill_done, (k == int'(LAST_BEAT)) ? 1 : 0);
    end
    fill_valid = 1'b0;
    chk("fill_busy_done", fill_busy, 0);
    tick();
    chk("fill_done_pulse", fill_done, 0);
  endtask

  typedef struct {
    logic [WAY_W-1:0] way;
    logic [IDX_W-1:0] idx;
    logic [OFF_W-1:0] woff;
    logic [3:0]       strb;
    logic [31:0]      wdata;
    logic [OFF_W-1:0] roff;
    logic [31:0]      exp;
  } vec_t;

  vec_t vecs[8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exceeded");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1);
  end

  initial begin
    vecs[0] = '{1'b1, 6'd5,  6'd0,  4'hF, 32'hDDCCBBAA, 6'd0,  32'hDDCCBBAA};
    vecs[1] = '{1'b0, 6'd5,  6'd0,  4'hF, 32'h11111111, 6'd0,  32'h11111111};
    vecs[2] = '{1'b1, 6'd5,  6'd0,  4'h0, 32'h00000000, 6'd0,  32'hDDCCBBAA};
    vecs[3] = '{1'b1, 6'd5,  6'd4,  4'hF, 32'h87654321, 6'd2,  32'h4321DDCC};
    vecs[4] = '{1'b0, 6'd7,  6'd62, 4'hF, 32'h44332211, 6'd62, 32'h44332211};
    vecs[5] = '{1'b1, 6'd5,  6'd1,  4'hA, 32'hA0B0C0D0, 6'd0,  32'hDDC0BBAA};
    vecs[6] = '{1'b1, 6'd5,  6'd0,  4'h0, 32'h00000000, 6'd3,  32'h6543A0DD};
    vecs[7] = '{1'b0, 6'd63, 6'd60, 4'hF, 32'hCAFEBABE, 6'd60, 32'hCAFEBABE};

    rst = 1'b1;
    rd_en = 1'b0; rd_way = '0; rd_index = '0; rd_offset = '0;
    wr_en = 1'b0; wr_way = '0; wr_index = '0; wr_offset = '0; wr_strb = '0; wr_data = '0;
    fill_start = 1'b0; fill_way = '0; fill_index = '0; fill_valid = 1'b0; fill_data = '0;
    tick();
    tick();
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_fill_ready", fill_ready, 0);
    chk("rst_fill_busy", fill_busy, 0);
    chk("rst_fill_done", fill_done, 0);
    chk("rst_wr_ready", wr_ready, 1);
    rst = 1'b0;
    tick();

    foreach (vecs[i]) begin
      store(vecs[i].way, vecs[i].idx, vecs[i].woff, vecs[i].strb, vecs[i].wdata);
      read_chk(vecs[i].way, vecs[i].idx, vecs[i].roff, vecs[i].exp);
    end

    // Line fill with byte b = b, then wrap-around reads
    do_fill(1'b1, 6'd9, 8'h00);
    read_chk(1'b1, 6'd9, 6'd62, 32'h01003F3E);
    read_chk(1'b1, 6'd9, 6'd0,  32'h03020100);

    // Same-cycle store and read: strobed bytes forwarded
    store(1'b0, 6'd10, 6'd8, 4'hF, 32'hFFFFFFFF);
    wr_en = 1'b1; wr_way = 1'b0; wr_index = 6'd10; wr_offset = 6'd8; wr_strb = 4'b0101; wr_data = 32'h11223344;
    rd_en = 1'b1; rd_way = 1'b0; rd_index = 6'd10; rd_offset = 6'd8;
    exp_q.push_back(32'hFF22FF44);
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    @(negedge clk);
    #1;
    chk("fwd_drained", exp_q.size(), 0);
    read_chk(1'b0, 6'd10, 6'd8, 32'hFF22FF44);

    // Refill way0/set3 with bubbles; hazard read stalls, other way proceeds, store held
    store(1'b1, 6'd3, 6'd0, 4'hF, 32'h55667788);
    fill_start = 1'b1; fill_way = 1'b0; fill_index = 6'd3;
    tick();
    fill_start = 1'b0;
    chk("fill3_busy", fill_busy, 1);
    wr_en = 1'b1; wr_way = 1'b1; wr_index = 6'd3; wr_offset = 6'd4; wr_strb = 4'hF; wr_data = 32'hA5A5A5A5;
    for (int c = 0; c < 2*BEATS; c++) begin
      fill_valid = (c % 2 == 1);
      fill_data  = beat(8'h40, c / 2);
      rd_en      = (c == 0) || (c == 2);
      rd_way     = (c == 0) ? 1'b0 : 1'b1;
      rd_index   = 6'd3;
      rd_offset  = 6'd0;
      #1;
      chk("fill3_wr_ready", wr_ready, 0);
      if (c == 0) chk("fill3_stall_hit", rd_stall, 1);
      if (c == 2) begin
        chk("fill3_stall_other", rd_stall, 0);
        exp_q.push_back(32'h55667788);
      end
      tick();
      rd_en = 1'b0;
      if (c == 0) chk("fill3_stall_no_valid", rd_valid, 0);
      chk("fill3_done", fill_done, (c == 2*BEATS - 1) ? 1 : 0);
      chk("fill3_busy_run", fill_busy, (c == 2*BEATS - 1) ? 0 : 1);
    end
    fill_valid = 1'b0;
    chk("fill3_wr_ready_done", wr_ready, 1);
    tick();
    wr_en = 1'b0;
    chk("fill3_done_clear", fill_done, 0);
    read_chk(1'b0, 6'd3, 6'd0,  32'h43424140);
    read_chk(1'b0, 6'd3, 6'd60, 32'h7F7E7D7C);
    read_chk(1'b1, 6'd3, 6'd4,  32'hA5A5A5A5);
    read_chk(1'b1, 6'd3, 6'd0,  32'h55667788);

    // Reset after 3 beats aborts the refill without fill_done
    fill_start = 1'b1; fill_way = 1'b1; fill_index = 6'd12;
    tick();
    fill_start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      fill_valid = 1'b1;
      fill_data  = beat(8'h90, k);
      tick();
      chk("abort_busy", fill_busy, 1);
    end
    fill_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy_rst", fill_busy, 0);
    chk("abort_ready_rst", fill_ready, 0);
    chk("abort_done_rst", fill_done, 0);
    chk("abort_wr_ready", wr_ready, 1);
    do_fill(1'b1, 6'd12, 8'hC0);
    read_chk(1'b1, 6'd12, 6'd0,  32'hC3C2C1C0);
    read_chk(1'b1, 6'd12, 6'd20, 32'hD7D6D5D4);

    tick();
    chk("final_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
